d2d_vc_credit_link: RTL and testbench

Credit-based die-to-die transmit link for multi-chip modules, sitting between on-die producers and the D2D PHY adapter. It multiplexes NUM_VC virtual channels onto one link using round-robin arbitration. Each VC has its own credit counter, replenished by credit returns from the peer die. Output is a registered valid/ready stage, so the PHY can apply backpressure without losing flits or credits.

---
 rtl/d2d_link_pkg.sv | 27 ++
 rtl/d2d_rr_arbiter.sv | 59 +++++
 rtl/d2d_vc_credit_link.sv | 167 ++++++++++++++++
 tb/tb_d2d_vc_credit_link.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d2d_link_pkg.sv
// Shared widths, defaults and flit type for the die-to-die credit link.
// Optional starvation watchdog in the top is enabled by D2D_CREDIT_TIMEOUT_EN.
package d2d_link_pkg;

    localparam int NUM_VC_DEF      = 4;
    localparam int CREDITS_DEF     = 8;
    localparam int DATA_W_DEF      = 64;
    localparam int TIMEOUT_CYC_DEF = 1024;

    // VC tag width: max(1, clog2(n))
    function automatic int vcw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Credit counter width: enough to hold 0..c inclusive
    function automatic int cw_f(input int c);
        return $clog2(c + 1);
    endfunction

    localparam int VCW_DEF = vcw_f(NUM_VC_DEF);

    typedef struct packed {
        logic [VCW_DEF-1:0]    vc;
        logic [DATA_W_DEF-1:0] data;
    } d2d_flit_t;

endpackage

// File: rtl/d2d_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from a rotating priority pointer.
// The pointer moves past the winner only when advance is asserted and a grant is made.
module d2d_rr_arbiter
    import d2d_link_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int PW = vcw_f(N);
    localparam logic [PW:0] N_L = (PW+1)'(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW:0]   nxt;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        sum   = '0;
        nxt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= N_L) begin
                sum = sum - N_L;
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt      = {1'b0, idx} + (PW+1)'(1);
                if (nxt >= N_L) begin
                    nxt = '0;
                end
                if (adv) begin
                    ptr_d = nxt[PW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/d2d_vc_credit_link.sv
// Credit-based multi-VC die-to-die transmit link with a registered valid/ready output.
// Define D2D_CREDIT_TIMEOUT_EN to build the per-VC starvation watchdog (stall_err).
module d2d_vc_credit_link
    import d2d_link_pkg::*;
#(
    parameter int NUM_VC      = NUM_VC_DEF,
    parameter int CREDITS     = CREDITS_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int VCW        = vcw_f(NUM_VC),
    localparam int CW         = cw_f(CREDITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_VC-1:0]        in_valid,
    output logic [NUM_VC-1:0]        in_ready,
    input  logic [NUM_VC*DATA_W-1:0] in_data,
    output logic                     link_valid,
    input  logic                     link_ready,
    output logic [VCW-1:0]           link_vc,
    output logic [DATA_W-1:0]        link_data,
    input  logic                     crd_ret_valid,
    input  logic [VCW-1:0]           crd_ret_vc,
    input  logic [CW-1:0]            crd_ret_cnt,
    output logic [NUM_VC*CW-1:0]     crd_avail,
    output logic                     crd_err,
    output logic [NUM_VC-1:0]        stall_err
);

    localparam logic [CW:0]  CRED_L   = (CW+1)'(CREDITS);
    localparam logic [VCW:0] NUM_VC_L = (VCW+1)'(NUM_VC);

    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] req;
    logic [NUM_VC-1:0] gnt;
    logic [NUM_VC-1:0] ovf;
    logic              slot_free;

    logic              link_valid_q, link_valid_d;
    logic [VCW-1:0]    link_vc_q, link_vc_d;
    logic [DATA_W-1:0] link_data_q, link_data_d;
    logic              crd_err_q, crd_err_d;
    logic [VCW-1:0]    gidx;
    logic [DATA_W-1:0] data_sel;

    // A held flit blocks the slot; credits already paid for it at capture time.
    assign slot_free = !link_valid_q || link_ready;
    assign req       = eligible & {NUM_VC{slot_free}};
    assign in_ready  = gnt;

    d2d_rr_arbiter #(.N(NUM_VC)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .adv (slot_free),
        .gnt (gnt)
    );

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic [CW-1:0] cred_q, cred_d;
            logic [CW:0]   sum;
            logic          ret_hit;

            assign ret_hit = crd_ret_valid && (crd_ret_vc == VCW'(gi));

            // A consume implies cred_q > 0, so the subtraction never wraps.
            always_comb begin
                sum = {1'b0, cred_q}
                    + (ret_hit ? {1'b0, crd_ret_cnt} : '0)
                    - (gnt[gi] ? (CW+1)'(1) : '0);
                ovf[gi] = (sum > CRED_L);
                cred_d  = ovf[gi] ? CRED_L[CW-1:0] : sum[CW-1:0];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cred_q <= CRED_L[CW-1:0];
                end else begin
                    cred_q <= cred_d;
                end
            end

            assign eligible[gi]            = in_valid[gi] && (cred_q != '0);
            assign crd_avail[gi*CW +: CW]  = cred_q;

`ifdef D2D_CREDIT_TIMEOUT_EN
            localparam int TW = $clog2(TIMEOUT_CYC + 1);
            localparam logic [TW-1:0] TO_L = TW'(TIMEOUT_CYC);
            logic [TW-1:0] wd_cnt_q, wd_cnt_d;
            logic          stall_q, stall_d;

            always_comb begin
                wd_cnt_d = '0;
                if (in_valid[gi] && (cred_q == '0)) begin
                    wd_cnt_d = (wd_cnt_q == TO_L) ? wd_cnt_q : wd_cnt_q + TW'(1);
                end
                stall_d = stall_q || (wd_cnt_d == TO_L);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_cnt_q <= '0;
                    stall_q  <= 1'b0;
                end else begin
                    wd_cnt_q <= wd_cnt_d;
                    stall_q  <= stall_d;
                end
            end

            assign stall_err[gi] = stall_q;
`else
            assign stall_err[gi] = 1'b0;
`endif
        end
    endgenerate

`ifndef D2D_CREDIT_TIMEOUT_EN
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_comb begin
        gidx     = '0;
        data_sel = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (gnt[v]) begin
                gidx     = VCW'(v);
                data_sel = in_data[v*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        link_valid_d = link_valid_q;
        link_vc_d    = link_vc_q;
        link_data_d  = link_data_q;
        if (|gnt) begin
            link_valid_d = 1'b1;
            link_vc_d    = gidx;
            link_data_d  = data_sel;
        end else if (link_ready) begin
            link_valid_d = 1'b0;
        end
        crd_err_d = crd_err_q || (|ovf)
                 || (crd_ret_valid && ({1'b0, crd_ret_vc} >= NUM_VC_L));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid_q <= 1'b0;
            link_vc_q    <= '0;
            link_data_q  <= '0;
            crd_err_q    <= 1'b0;
        end else begin
            link_valid_q <= link_valid_d;
            link_vc_q    <= link_vc_d;
            link_data_q  <= link_data_d;
            crd_err_q    <= crd_err_d;
        end
    end

    assign link_valid = link_valid_q;
    assign link_vc    = link_vc_q;
    assign link_data  = link_data_q;
    assign crd_err    = crd_err_q;

endmodule

// File: tb/tb_d2d_vc_credit_link.sv
// Self-checking bench for d2d_vc_credit_link: directed scenarios plus random traffic
// compared every cycle against a queue-free behavioural model of credits, RR order and output slot.
module tb_d2d_vc_credit_link;

    localparam int NV  = 4;
    localparam int CR  = 8;
    localparam int DW  = 16;
    localparam int TO  = 16;
    localparam int VCW = 2;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NV-1:0]     in_valid = '0;
    logic [NV-1:0]     in_ready;
    logic [NV*DW-1:0]  in_data = '0;
    logic              link_valid;
    logic              link_ready = 1'b0;
    logic [VCW-1:0]    link_vc;
    logic [DW-1:0]     link_data;
    logic              crd_ret_valid = 1'b0;
    logic [VCW-1:0]    crd_ret_vc = '0;
    logic [CW-1:0]     crd_ret_cnt = '0;
    logic [NV*CW-1:0]  crd_avail;
    logic              crd_err;
    logic [NV-1:0]     stall_err;

    // Second instance with 3 VCs so an unencodable-for-NUM_VC tag can be returned.
    logic [2:0]        in_ready3;
    logic              link_valid3;
    logic [1:0]        link_vc3;
    logic [DW-1:0]     link_data3;
    logic              ret_valid3 = 1'b0;
    logic [1:0]        ret_vc3 = '0;
    logic [CW-1:0]     ret_cnt3 = '0;
    logic [3*CW-1:0]   crd_avail3;
    logic              crd_err3;
    logic [2:0]        stall_err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d2d_vc_credit_link #(.NUM_VC(NV), .CREDITS(CR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .link_valid(link_valid), .link_ready(link_ready), .link_vc(link_vc), .link_data(link_data),
        .crd_ret_valid(crd_ret_valid), .crd_ret_vc(crd_ret_vc), .crd_ret_cnt(crd_ret_cnt),
        .crd_avail(crd_avail), .crd_err(crd_err), .stall_err(stall_err)
    );

    d2d_vc_credit_link #(.NUM_VC(3), .CREDITS(CR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut3 (
        .clk(clk), .rst(rst), .in_valid(3'b000), .in_ready(in_ready3), .in_data({3*DW{1'b0}}),
        .link_valid(link_valid3), .link_ready(1'b1), .link_vc(link_vc3), .link_data(link_data3),
        .crd_ret_valid(ret_valid3), .crd_ret_vc(ret_vc3), .crd_ret_cnt(ret_cnt3),
        .crd_avail(crd_avail3), .crd_err(crd_err3), .stall_err(stall_err3)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cav(input int v);
        return int'(crd_avail[v*CW +: CW]);
    endfunction

    // ---------------- behavioural model ----------------
    int            m_cred[NV];
    int            m_run[NV];
    int            m_ptr;
    bit            m_valid;
    int            m_vc;
    logic [DW-1:0] m_data;
    bit            m_err;
    bit [NV-1:0]   m_stall;
    bit            m_ok = 1'b0;

    function automatic int m_grant();
        if (m_valid && !link_ready) return -1;
        for (int k = 0; k < NV; k++) begin
            int v;
            v = (m_ptr + k) % NV;
            if (in_valid[v] && m_cred[v] > 0) return v;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [NV-1:0] exp_rdy;
        if (m_ok) begin
            g = m_grant();
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("in_ready", in_ready, exp_rdy);
            chk("link_valid", link_valid, m_valid);
            chk("link_vc", link_vc, m_vc);
            chk("link_data", link_data, m_data);
            chk("crd_err", crd_err, m_err);
            chk("stall_err", stall_err, m_stall);
            for (int v = 0; v < NV; v++) chk($sformatf("crd_avail[%0d]", v), cav(v), m_cred[v]);
        end
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                m_cred[v] = CR;
                m_run[v]  = 0;
            end
            m_ptr = 0; m_valid = 0; m_vc = 0; m_data = '0; m_err = 0; m_stall = '0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            g = m_grant();
`ifdef D2D_CREDIT_TIMEOUT_EN
            for (int v = 0; v < NV; v++) begin
                m_run[v] = (in_valid[v] && m_cred[v] == 0) ? m_run[v] + 1 : 0;
                if (m_run[v] >= TO) m_stall[v] = 1'b1;
            end
`endif
            if (g >= 0) begin
                m_valid = 1; m_vc = g; m_data = in_data[g*DW +: DW];
                m_ptr = (g + 1) % NV;
            end else if (link_ready) begin
                m_valid = 0;
            end
            for (int v = 0; v < NV; v++) begin
                int s;
                s = m_cred[v] - ((g == v) ? 1 : 0)
                  + ((crd_ret_valid && int'(crd_ret_vc) == v) ? int'(crd_ret_cnt) : 0);
                if (s > CR) begin
                    s = CR;
                    m_err = 1;
                end
                m_cred[v] = s;
            end
            if (crd_ret_valid && int'(crd_ret_vc) >= NV) m_err = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
        in_data = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; link_ready = 1'b0; crd_ret_valid = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    function automatic int oh2i(input logic [NV-1:0] oh);
        for (int v = 0; v < NV; v++) if (oh[v]) return v;
        return -1;
    endfunction

    initial begin
        int n;
        int ord[6];
        logic [DW-1:0] exp_d;

        do_reset();
        chk("rst_link_valid", link_valid, 0);
        chk("rst_crd_avail", crd_avail, {NV{4'd8}});
        chk("rst_crd_err", crd_err, 0);

        // Illegal VC tag on the 3-VC instance
        chk("vc3_err_before", crd_err3, 0);
        ret_valid3 = 1'b1; ret_vc3 = 2'd3; ret_cnt3 = 4'd1;
        step();
        ret_valid3 = 1'b0;
        chk("vc3_err_after", crd_err3, 1);
        chk("vc3_credits", crd_avail3, {3{4'd8}});

        // Single-VC drain, then a 3-credit return
        do_reset();
        in_valid = 4'b0010; link_ready = 1'b1;
        n = 0;
        repeat (12) begin
            step();
            if (link_valid && link_vc == 2'd1) n++;
        end
        chk("drain_flits", n, 8);
        chk("drain_crd1", cav(1), 0);
        chk("drain_ready", in_ready, 0);
        crd_ret_valid = 1'b1; crd_ret_vc = 2'd1; crd_ret_cnt = 4'd3;
        step();
        crd_ret_valid = 1'b0;
        n = 0;
        repeat (6) begin
            step();
            if (link_valid && link_vc == 2'd1) n++;
        end
        chk("return3_flits", n, 3);

        // Round-robin order with ample credits
        do_reset();
        in_valid = 4'hF; link_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_order[%0d]", i), oh2i(in_ready), i % NV);
            step();
        end

        // VC2 drained to zero: pointer now after VC2, order skips it
        do_reset();
        in_valid = 4'b0100; link_ready = 1'b1;
        repeat (8) step();
        chk("vc2_empty", cav(2), 0);
        in_valid = 4'hF;
        ord = '{3, 0, 1, 3, 0, 1};
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_skip[%0d]", i), oh2i(in_ready), ord[i]);
            step();
        end

        // Backpressure
        do_reset();
        in_valid = 4'b0001; link_ready = 1'b0;
        step();
        chk("bp_valid", link_valid, 1);
        repeat (5) begin
            step();
            chk("bp_hold_valid", link_valid, 1);
            chk("bp_no_ready", in_ready, 0);
            chk("bp_crd0", cav(0), 7);
        end
        link_ready = 1'b1;
        exp_d = in_data[DW-1:0];
        #1;
        chk("bp_release_ready", in_ready, 4'b0001);
        step();
        chk("bp_next_data", link_data, exp_d);
        chk("bp_next_crd0", cav(0), 6);

        // Simultaneous consume and return on VC0
        do_reset();
        in_valid = 4'b0001; link_ready = 1'b1;
        repeat (4) step();
        chk("sim_crd0_pre", cav(0), 4);
        crd_ret_valid = 1'b1; crd_ret_vc = 2'd0; crd_ret_cnt = 4'd2;
        step();
        crd_ret_valid = 1'b0; in_valid = '0;
        chk("sim_crd0_post", cav(0), 5);

        // Overflow on a full VC
        do_reset();
        crd_ret_valid = 1'b1; crd_ret_vc = 2'd3; crd_ret_cnt = 4'd1;
        step();
        crd_ret_valid = 1'b0;
        chk("ovf_crd3", cav(3), 8);
        chk("ovf_err", crd_err, 1);

        // Reset with a flit in flight
        do_reset();
        in_valid = 4'b0001; link_ready = 1'b0;
        step();
        chk("mid_valid_pre", link_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = '0;
        chk("mid_valid_post", link_valid, 0);
        chk("mid_credits", crd_avail, {NV{4'd8}});

`ifdef D2D_CREDIT_TIMEOUT_EN
        do_reset();
        in_valid = 4'b0001; link_ready = 1'b1;
        repeat (8) step();
        chk("wd_stall_pre", stall_err[0], 0);
        n = 0;
        while (!stall_err[0] && n < 40) begin
            step();
            n++;
        end
        chk("wd_cycles", n, TO);
        in_valid = '0;
`endif

        // Random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            in_valid      = NV'($urandom);
            link_ready    = ($urandom_range(0, 9) < 7);
            crd_ret_valid = ($urandom_range(0, 3) == 0);
            crd_ret_vc    = VCW'($urandom);
            crd_ret_cnt   = ($urandom_range(0, 15) == 0) ? CW'(CR) : CW'($urandom_range(0, 3));
            step();
        end
        rst = 1'b0; in_valid = '0; crd_ret_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
